eda_neigh_fifo: RTL

- Downstream of the 3x3 region-max compare stage.
- Takes the 8-bit push_positions mask for a centre pixel and converts each set bit into an absolute neighbour pixel address.
- Serialises those addresses, one per cycle, into a circular FIFO.
- The FIFO is the flood-fill work queue read by the window fetch controller.

---
 rtl/eda_neigh_fifo_pkg.sv | 16 +
 rtl/eda_prio_enc.sv | 18 +
 rtl/eda_neigh_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/eda_neigh_fifo_pkg.sv
// eda_pkg: shared constants, window-offset tables and FSM state type for the neighbour FIFO
package eda_pkg;

    localparam int NEIGH_NUM = 8;

    localparam int DR [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int DC [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

    typedef enum logic {IDLE, SER} state_t;

    // Mask bits skip the window centre (index 4)
    function automatic logic [3:0] pos_to_win(input logic [2:0] k);
        return (k < 3'd4) ? {1'b0, k} : {1'b0, k} + 4'd1;
    endfunction

endpackage

// File: rtl/eda_prio_enc.sv
// eda_prio_enc: lowest-set-bit finder over the neighbour mask
module eda_prio_enc
    import eda_pkg::*;
(
    input  logic [NEIGH_NUM-1:0] mask,
    output logic [2:0]           idx,
    output logic                 found
);

    always_comb begin
        idx = '0;
        for (int i = NEIGH_NUM - 1; i >= 0; i--)
            if (mask[i]) idx = 3'(i);
    end

    assign found = |mask;

endmodule

// File: rtl/eda_neigh_fifo.sv
// eda_neigh_fifo: serialises a neighbour mask into absolute pixel addresses in a circular work queue.
// Define EDA_NEIGH_FIFO_HWM_EN to add the hwm (occupancy high-water mark) output.
module eda_neigh_fifo
    import eda_pkg::*;
#(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int ADDR_WIDTH = $clog2(M * N),
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [7:0]            push_positions,
    input  logic [ADDR_WIDTH-1:0] center_addr,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] pop_addr,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  count,
`ifdef EDA_NEIGH_FIFO_HWM_EN
    output logic [CNT_WIDTH-1:0]  hwm,
`endif
    output logic                  busy
);

    localparam int PW = $clog2(DEPTH);

    state_t                state, state_nxt;
    logic [7:0]            mask_q, mask_nxt;
    logic [ADDR_WIDTH-1:0] center_q, wr_addr;
    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [2:0]            idx;
    logic [3:0]            win;
    logic                  found, pop_ok, wr_en, accept;

    eda_prio_enc u_enc (
        .mask  (mask_q),
        .idx   (idx),
        .found (found)
    );

    assign push_ready = (state == IDLE);
    assign busy       = (state == SER);
    assign empty      = (count == '0);
    assign full       = (count == CNT_WIDTH'(DEPTH));
    assign pop_addr   = empty ? '0 : mem[rd_ptr];
    assign accept     = push_valid && push_ready;
    assign pop_ok     = pop && !empty;
    // A full queue still takes a write when the head leaves in the same cycle
    assign wr_en      = busy && found && (!full || pop_ok) && !flush;
    assign win        = pos_to_win(idx);
    assign wr_addr    = center_q + ADDR_WIDTH'(DR[win] * N + DC[win]);
    assign mask_nxt   = mask_q & ~(8'd1 << idx);
    assign count_nxt  = flush ? '0 : count + CNT_WIDTH'(wr_en) - CNT_WIDTH'(pop_ok);

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = IDLE;
        else if (accept && |push_positions)
            state_nxt = SER;
        else if (wr_en && mask_nxt == '0)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mask_q   <= '0;
            center_q <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (flush) begin
                mask_q   <= '0;
                center_q <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (accept) begin
                    mask_q   <= push_positions;
                    center_q <= center_addr;
                end else if (wr_en) begin
                    mask_q <= mask_nxt;
                end
                if (wr_en) wr_ptr <= wr_ptr + PW'(1);
                if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= wr_addr;

`ifdef EDA_NEIGH_FIFO_HWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hwm <= '0;
        else if (flush)
            hwm <= '0;
        else if (count_nxt > hwm)
            hwm <= count_nxt;
    end
`endif

endmodule
